mult_div_unit: RTL
==================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline. It sits in the execute stage and accepts mult/multu/div/divu/mthi/mtlo operations issued from E. It exposes HI/LO to mfhi/mflo readers. It also drives the busy/stall handshake that the pipeline hazard logic uses to hold D while a long operation is in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low (sampled on rising edge of clk)
- md_op  in  3  E-stage operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
- a  in  32  E-stage rs value (forwarded)
- b  in  32  E-stage rt value (forwarded)
- rd_sel  in  1  read select: 0 LO, 1 HI
- md_use_D  in  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  long operation in progress
- md_stall  out  1  request to stall F/D and flush E
- hi  out  32  HI register
- lo  out  32  LO register
- md_rdata  out  32  rd_sel ? hi : lo (combinational)

## Operation
- State: IDLE, RUN. Counter cnt sized to max(MULT_CYCLES, DIV_CYCLES). pend_hi/pend_lo hold the 64-bit pending result.
- IDLE, md_op = mult/multu/div/divu: latch the result of a, b into pend_hi/pend_lo at the edge. Load cnt with the op's cycle count. Go to RUN.
- mult: signed 32x32 product. multu: unsigned product. Upper 32 bits go to pend_hi, lower 32 bits to pend_lo.
- div: signed division. pend_lo gets the quotient, truncated toward zero. pend_hi gets the remainder, which takes the dividend's sign. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- divu: unsigned division.
- Divide by zero (b=0): the op still runs DIV_CYCLES, but hi/lo are left unchanged at commit.
- IDLE, mthi/mtlo: write a to hi/lo at the edge. busy stays 0, no RUN.
- RUN: decrement cnt each edge. On the edge where cnt reaches 1, commit pend_hi to hi and pend_lo to lo, then return to IDLE.
- Any md_op in RUN is ignored; the hazard logic guarantees none arrives.
- busy = (state==RUN).
- md_stall = md_use_D & (busy | md_op ∈ {mult, multu, div, divu}).
- Reset: state IDLE, cnt 0, busy 0, hi 0, lo 0, pend 0. md_stall is 0 unless md_use_D is high during a start-issuing cycle.
- Reset mid-operation: the pending result is discarded, hi/lo clear to 0, and state goes to IDLE at that edge.

## Timing
- Start sampled at edge E0, the end of cycle t with md_op valid. busy=1 in cycles t+1 .. t+N (N = MULT_CYCLES or DIV_CYCLES).
- hi/lo take the new value at the edge ending cycle t+N. The value is visible in cycle t+N+1, the same cycle busy=0.
- Back-to-back starts: a start in cycle t+N+1 is accepted.
- mthi/mtlo: the new value is visible in the cycle after issue.
- md_rdata reads hi/lo combinationally. An mfhi/mflo issued after a write sees the updated value one cycle later.
- md_stall is combinational from md_use_D, busy, md_op. It is high in cycle t (start cycle) and in t+1..t+N when md_use_D=1.

## Test plan
- Reset check:
  - Stimulus: hold rst_n=0 for 2 cycles.
  - Response: hi=lo=0, busy=0, md_rdata=0.
- mult, then mflo/mfhi:
  - Stimulus: mult a=0xFFFFFFFE (-2), b=3.
  - Response: busy high exactly 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Response: multu with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- div signed:
  - Stimulus: div a=-7 (0xFFFFFFF9), b=2.
  - Response: busy 10 cycles. Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - Stimulus: divu a=7, b=2.
  - Response: lo=3, hi=1.
- Divide by zero:
  - Stimulus: mthi 0x11111111, mtlo 0x22222222, then div b=0.
  - Response: busy 10 cycles. hi/lo stay 0x11111111/0x22222222.
- Stall handshake:
  - Stimulus: start mult with md_use_D=1 held.
  - Response: md_stall=1 in the start cycle and the 5 busy cycles, then 0.
  - Stimulus: repeat with md_use_D=0.
  - Response: md_stall stays 0 throughout.
- Reset mid-op:
  - Stimulus: start div, then rst_n=0 at the 4th busy cycle.
  - Response: the next cycle has busy=0 and hi=lo=0. A subsequent mult 6×7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_div_unit: multi-cycle MIPS multiply/divide with HI/LO and stall     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int       c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int       c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [2:0] c_OP_MULT  = 3'b001;
  localparam logic [2:0] c_OP_MULTU = 3'b010;
  localparam logic [2:0] c_OP_DIV   = 3'b011;
  localparam logic [2:0] c_OP_DIVU  = 3'b100;
  localparam logic [2:0] c_OP_MTHI  = 3'b101;
  localparam logic [2:0] c_OP_MTLO  = 3'b110;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic [31:0]          r_pendHi;
  logic [31:0]          r_pendLo;
  logic                 r_divZero;

  logic                 w_isMult;
  logic                 w_isDiv;
  logic                 w_start;
  logic                 w_bZero;
  logic [31:0]          w_bSafe;
  logic signed [63:0]   w_sProd;
  logic [63:0]          w_uProd;
  logic signed [31:0]   w_sQuot;
  logic signed [31:0]   w_sRem;
  logic [31:0]          w_uQuot;
  logic [31:0]          w_uRem;
  logic [31:0]          w_resHi;
  logic [31:0]          w_resLo;
  logic [c_CNT_W-1:0]   w_cntLoad;

  assign w_isMult = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU);
  assign w_isDiv  = (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);
  assign w_start  = w_isMult || w_isDiv;
  assign w_bZero  = (b == 32'd0);
  // Divider never sees zero; the result is discarded via r_divZero anyway.
  assign w_bSafe  = w_bZero ? 32'd1 : b;

  assign w_sProd  = $signed(a) * $signed(b);
  assign w_uProd  = {32'd0, a} * {32'd0, b};
  assign w_sQuot  = $signed(a) / $signed(w_bSafe);
  assign w_sRem   = $signed(a) % $signed(w_bSafe);
  assign w_uQuot  = a / w_bSafe;
  assign w_uRem   = a % w_bSafe;

  always_comb begin
    w_resHi = 32'd0;
    w_resLo = 32'd0;
    case (md_op)
      c_OP_MULT:  begin w_resHi = w_sProd[63:32]; w_resLo = w_sProd[31:0]; end
      c_OP_MULTU: begin w_resHi = w_uProd[63:32]; w_resLo = w_uProd[31:0]; end
      c_OP_DIV: begin
        // INT_MIN / -1 overflows; wrap explicitly instead of relying on the tool.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          w_resHi = 32'd0;
          w_resLo = 32'h8000_0000;
        end else begin
          w_resHi = w_sRem;
          w_resLo = w_sQuot;
        end
      end
      c_OP_DIVU:  begin w_resHi = w_uRem; w_resLo = w_uQuot; end
      default:    ;
    endcase
  end

  assign w_cntLoad = w_isMult ? c_CNT_W'(MULT_CYCLES) : c_CNT_W'(DIV_CYCLES);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_stateNext = S_RUN;
      S_RUN:   if (r_cnt == c_CNT_W'(1)) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pendHi  <= 32'd0;
      r_pendLo  <= 32'd0;
      r_divZero <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_pendHi  <= w_resHi;
        r_pendLo  <= w_resLo;
        r_divZero <= w_isDiv && w_bZero;
        r_cnt     <= w_cntLoad;
      end else if (md_op == c_OP_MTHI) begin
        r_hi <= a;
      end else if (md_op == c_OP_MTLO) begin
        r_lo <= a;
      end
    end else begin
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (r_cnt == c_CNT_W'(1) && !r_divZero) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign md_stall = md_use_D && (busy || w_start);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_rdata = rd_sel ? r_hi : r_lo;

endmodule
`default_nettype wire
